// File: rtl/tri_bus_arbiter.sv
// Purpose : round-robin arbiter that puts one of CHANNELS requesters onto a shared
//           WIDTH-bit tri-state bus, with bounded bursts and a high-Z turnaround
//           between owners.
// Latency : a request sampled in IDLE is granted and driven right after that same
//           edge. Back-to-back owners are separated by TURN_CYCLES high-Z cycles.
// Backpressure: a word on DATA_IN[i] is consumed at an edge iff GNT[i]=1 after that
//           edge. The requester holds REQ[i] and its word until it sees acceptance.
// Ports   : CLK/RST_N (async active-low); REQ, DATA_IN (channel i at [i*WIDTH +: WIDTH]);
//           GNT (one-hot owner), OE, X (bus, 'bz when OE=0), OWNER (current/last owner).
module tri_bus_arbiter #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int MAX_BURST   = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [CHANNELS-1:0]           REQ,
    input  logic [CHANNELS*WIDTH-1:0]     DATA_IN,
    output logic [CHANNELS-1:0]           GNT,
    output logic                          OE,
    output logic [WIDTH-1:0]              X,
    output logic [$clog2(CHANNELS)-1:0]   OWNER
);

    localparam int OW = $clog2(CHANNELS);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TURN_CYCLES + 1);

    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
    localparam logic [OW-1:0] CH_LAST   = OW'(CHANNELS - 1);
    localparam logic [OW:0]   CH_NUM    = (OW+1)'(CHANNELS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_TURN
    } state_t;

    state_t             state_q, state_d;
    logic [CHANNELS-1:0] gnt_q, gnt_d;
    logic               oe_q, oe_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      ptr_q, ptr_d;
    logic [BW-1:0]      burst_q, burst_d;
    logic [TW-1:0]      turn_q, turn_d;
    logic [WIDTH-1:0]   data_q, data_d;

    // Round-robin search: first set REQ bit at or above ptr_q, wrapping around.
    logic               arb_found;
    logic [OW-1:0]      arb_idx;
    logic [OW:0]        arb_sum;
    logic [OW-1:0]      arb_cand;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = '0;
        arb_cand  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            // ptr_q + k stays below 2*CHANNELS, so one conditional subtract wraps it.
            arb_sum = {1'b0, ptr_q} + (OW+1)'(k);
            if (arb_sum >= CH_NUM) begin
                arb_sum = arb_sum - CH_NUM;
            end
            arb_cand = arb_sum[OW-1:0];
            if (!arb_found && REQ[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    logic [WIDTH-1:0] arb_word;
    logic [WIDTH-1:0] own_word;

    assign arb_word = DATA_IN[int'(arb_idx) * WIDTH +: WIDTH];
    assign own_word = DATA_IN[int'(owner_q) * WIDTH +: WIDTH];

    logic do_arb;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        oe_d    = oe_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        turn_d  = turn_q;
        data_d  = data_q;
        do_arb  = 1'b0;

        case (state_q)
            S_IDLE: begin
                do_arb = 1'b1;
            end
            S_DRIVE: begin
                if (REQ[owner_q] && (burst_q < BURST_MAX)) begin
                    data_d  = own_word;
                    burst_d = burst_q + 1'b1;
                end else begin
                    // The word on the bus input at this edge is not taken; the
                    // requester sees GNT drop and keeps presenting it.
                    gnt_d   = '0;
                    oe_d    = 1'b0;
                    ptr_d   = (owner_q == CH_LAST) ? '0 : owner_q + 1'b1;
                    turn_d  = '0;
                    state_d = S_TURN;
                end
            end
            S_TURN: begin
                turn_d = turn_q + 1'b1;
                if (turn_q == TURN_LAST) begin
                    do_arb = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                oe_d    = 1'b0;
            end
        endcase

        if (do_arb) begin
            if (arb_found) begin
                gnt_d          = '0;
                gnt_d[arb_idx] = 1'b1;
                owner_d        = arb_idx;
                oe_d           = 1'b1;
                data_d         = arb_word;
                burst_d        = BURST_ONE;
                state_d        = S_DRIVE;
            end else begin
                gnt_d   = '0;
                oe_d    = 1'b0;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            oe_q    <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            turn_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            oe_q    <= oe_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            turn_q  <= turn_d;
            data_q  <= data_d;
        end
    end

    assign GNT   = gnt_q;
    assign OE    = oe_q;
    assign OWNER = owner_q;
    // Bus driver depends only on registered state.
    assign X     = oe_q ? data_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Purpose : directed bench for tri_bus_arbiter (WIDTH=8, CHANNELS=4, MAX_BURST=4,
//           TURN_CYCLES=1) with hand-computed per-cycle expectations.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: requesters advance their word only after seeing their GNT bit.
module tb_tri_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data_in;
    wire  [3:0]  gnt;
    wire         oe;
    wire  [7:0]  x_bus;
    wire  [1:0]  owner;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tri_bus_arbiter #(
        .WIDTH       (8),
        .CHANNELS    (4),
        .MAX_BURST   (4),
        .TURN_CYCLES (1)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .REQ     (req),
        .DATA_IN (data_in),
        .GNT     (gnt),
        .OE      (oe),
        .X       (x_bus),
        .OWNER   (owner)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int ch, input logic [7:0] w);
        data_in[ch*8 +: 8] = w;
    endtask

    task automatic expect_drive(input string tag, input int ch, input logic [7:0] w);
        chk({tag, "_gnt"},   {28'd0, gnt},   32'(1) << ch);
        chk({tag, "_oe"},    {31'd0, oe},    32'd1);
        chk({tag, "_x"},     {24'd0, x_bus}, {24'd0, w});
        chk({tag, "_owner"}, {30'd0, owner}, 32'(ch));
    endtask

    task automatic expect_z(input string tag);
        chk({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
        chk({tag, "_oe"},  {31'd0, oe},  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int order [4];
        order = '{0, 1, 3, 0};

        // Reset with every channel requesting: nothing may be granted.
        rst_n   = 1'b0;
        req     = 4'hF;
        data_in = 32'h44332211;
        #3;
        expect_z("rst");
        chk("rst_owner", {30'd0, owner}, 32'd0);

        // Release reset with only ch2 requesting: granted on the first edge.
        req = 4'b0100;
        set_word(2, 8'hA5);
        #1 rst_n = 1'b1;
        tick(); expect_drive("first", 2, 8'hA5);
        req = 4'b0000;
        tick(); expect_z("first_rel");
        tick(); expect_z("first_idle");

        // Burst cap: ch0 alone with words 01..06; cap of 4 then one Z cycle.
        req = 4'b0001;
        set_word(0, 8'h01);
        for (int w = 1; w <= 4; w++) begin
            tick(); expect_drive("cap", 0, 8'(w));
            set_word(0, 8'(w + 1));
        end
        tick(); expect_z("cap_gap");
        tick(); expect_drive("cap_regain", 0, 8'h05);
        set_word(0, 8'h06);
        tick(); expect_drive("cap_w6", 0, 8'h06);
        req = 4'b0000;
        tick(); expect_z("cap_rel");
        tick(); expect_z("cap_idle");

        // Round-robin from ptr=0 with REQ=1011 held: 0,1,3,0 with gaps.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        req = 4'b1011;
        for (int c = 0; c < 4; c++) set_word(c, 8'(8'h10 + c));
        for (int j = 0; j < 4; j++) begin
            for (int b = 0; b < 4; b++) begin
                tick(); expect_drive("rr", order[j], 8'(8'h10 + order[j]));
            end
            tick(); expect_z("rr_gap");
        end
        req = 4'b0000;
        tick(); expect_z("rr_idle");

        // Early release: ptr=1 here, ch3 alone first, ch1 raises while ch3 owns.
        req = 4'b1000;
        set_word(3, 8'h30);
        tick(); expect_drive("early_w0", 3, 8'h30);
        set_word(3, 8'h31);
        set_word(1, 8'h51);
        req = 4'b1010;
        tick(); expect_drive("early_w1", 3, 8'h31);
        req = 4'b0010;
        tick(); expect_z("early_gap");
        tick(); expect_drive("early_next", 1, 8'h51);
        req = 4'b0000;
        tick(); expect_z("early_rel");
        tick(); expect_z("early_idle");

        // Async reset mid-burst: ptr=2 before reset, so ch3 wins from 2.
        req = 4'b1000;
        set_word(3, 8'h33);
        tick(); expect_drive("arst_pre", 3, 8'h33);
        #2 rst_n = 1'b0;
        #1;
        expect_z("arst_now");
        chk("arst_owner", {30'd0, owner}, 32'd0);
        #1 rst_n = 1'b1;
        // ch1 and ch2 both request: ptr back at 0 picks ch1, a stale ptr=2 would pick ch2.
        req = 4'b0110;
        set_word(1, 8'h61);
        set_word(2, 8'h62);
        tick(); expect_drive("arst_restart", 1, 8'h61);
        req = 4'b0000;
        tick(); expect_z("arst_rel");
        tick(); expect_z("arst_idle");

        // Idle: no requests for 10 cycles, bus stays undriven, OWNER holds last owner.
        for (int i = 0; i < 10; i++) begin
            tick(); expect_z("idle");
            chk("idle_owner", {30'd0, owner}, 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tri_bus_arbiter.md
# tri_bus_arbiter

Parametrised, clocked successor to the single tri-state buffer. It arbitrates CHANNELS requesters onto one shared WIDTH-bit tri-state bus. Ownership is round-robin, bursts are bounded, and every change of owner inserts a high-impedance turnaround so two drivers never overlap. It sits between the datapath sources and any shared internal bus in the processor.

## Interface
- WIDTH, 8, bus data width in bits (≥1)
- CHANNELS, 4, number of requesters (≥2)
- MAX_BURST, 8, maximum words per ownership (≥1)
- TURN_CYCLES, 1, high-Z cycles between owners (≥1)

- CLK  input  1  single clock; all state changes on rising edge
- RST_N  input  1  asynchronous, active-low reset
- REQ  input  CHANNELS  per-channel request; high means a word is presented on DATA_IN for that channel
- DATA_IN  input  CHANNELS*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
- GNT  output  CHANNELS  one-hot owner, registered; all zero when the bus is undriven
- OE  output  1  registered; high when X is driven
- X  output  WIDTH  shared bus: registered owner word when OE=1, 'bz otherwise
- OWNER  output  $clog2(CHANNELS)  index of current or last owner

## Operation
- Reset (async, RST_N=0): state=IDLE, GNT=0, OE=0, X='bz, OWNER=0, rr pointer=0, burst and turn counters=0. Outputs go to these values immediately, without waiting for an edge, including mid-burst.
- FSM states:
  - IDLE
  - DRIVE
  - TURN
- Arbitration (from IDLE, or at the last TURN cycle): search REQ from index ptr upward with wrap-around and take the first set bit, i.
  - Set GNT=onehot(i), OWNER=i, OE=1.
  - Load the data register from DATA_IN[i]. Set burst_cnt=1 and go to DRIVE.
  - With no REQ set, stay in or go to IDLE.
- DRIVE, at each edge:
  - If REQ[OWNER]=1 and burst_cnt<MAX_BURST, load DATA_IN[OWNER] and increment burst_cnt.
  - Otherwise set GNT=0 and OE=0, set ptr=(OWNER+1) mod CHANNELS, clear turn_cnt and go to TURN.
- TURN: X='bz. Increment turn_cnt each edge. At the edge where turn_cnt==TURN_CYCLES-1, arbitrate as above; with no request, go to IDLE.
- Acceptance rule: the word on DATA_IN[i] is consumed at an edge if and only if GNT[i]=1 immediately after that edge.
  - A requester holds REQ and its word stable until it sees acceptance.
  - The word presented at the edge that ends a burst is not accepted.
- Non-owner REQ bits are ignored during DRIVE and during non-final TURN cycles.
- Counter widths:
  - burst_cnt is $clog2(MAX_BURST+1) bits and saturates conceptually at MAX_BURST; it never wraps.
  - turn_cnt is $clog2(TURN_CYCLES+1) bits.
  - ptr wraps from CHANNELS-1 to 0.
- Contention invariant: OE is never high on two consecutive owners without at least TURN_CYCLES cycles of OE=0 between them. At most one GNT bit is ever set.

## Timing
- Grant latency: REQ sampled high at edge n in IDLE gives GNT, OE and X valid after edge n (zero wait cycles).
- Throughput: one word per cycle while the owner holds REQ, up to MAX_BURST words.
- Release: REQ dropped is sampled at edge m, so OE=0 and X='bz after edge m.
- Handover gap: exactly TURN_CYCLES cycles of high-Z before the next owner's first word, when another request is pending.
- X is a pure function of the registered OE and data, with no combinational path from REQ or DATA_IN.

## Test plan
Configuration for all scenarios: WIDTH=8, CHANNELS=4, MAX_BURST=4, TURN_CYCLES=1.
- Reset check: RST_N=0 with REQ=4'hF → GNT=0, OE=0, X=8'hzz. Release reset with REQ[2]=1 and DATA_IN ch2=8'hA5 → after the first edge, GNT=4'b0100, X=8'hA5.
- Burst cap: ch0 holds REQ for 6 cycles with words 01..06 → X shows 01,02,03,04, then one Z cycle; ch0 regains the bus and drives 05 if it is the only requester.
- Round-robin: REQ=4'b1011 held continuously → owner order 0,1,3,0 with a one-cycle Z gap between each. GNT is never multi-hot.
- Early release: ch3 granted, drops REQ after 2 words → X=w0,w1 then Z. The next pending ch1 is granted exactly 1 cycle later.
- Async reset mid-burst: RST_N asserted between edges during DRIVE → OE=0 and X='bz immediately. After release, arbitration restarts from ptr=0.
- Idle: REQ=0 for 10 cycles → state stays IDLE, OE=0 and X='bz throughout.
